// File: rtl/hiscore_ram_arbiter_pkg.sv
// Shared types for the hiscore RAM arbiter: FSM state encoding and counter widths.
package hs_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE_WAIT,
    S_SETTLE,
    S_GRANT,
    S_BLOCKED
  } hs_arb_state_t;

  localparam int TO_W  = 12;
  localparam int SET_W = 4;

endpackage

// File: rtl/hiscore_ram_arbiter_if.sv
// Hiscore engine side of the arbiter: access intent, address/data and grant/read-back status.
interface hiscore_ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
) ();

  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wdata;
  logic          hs_we;
  logic [DW-1:0] hs_rdata;
  logic          hs_rvalid;
  logic          hs_grant;
  logic          hs_timeout;

  modport master (
    output hs_req, hs_addr, hs_wdata, hs_we,
    input  hs_rdata, hs_rvalid, hs_grant, hs_timeout
  );

  modport slave (
    input  hs_req, hs_addr, hs_wdata, hs_we,
    output hs_rdata, hs_rvalid, hs_grant, hs_timeout
  );

endinterface

// File: rtl/hiscore_ram_arbiter_mux.sv
// RAM port mux between CPU and hiscore side, plus the hiscore read-data pipeline.
module hs_arb_mux #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          sel_hs,
  input  logic          rd_en,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  input  logic          hs_we,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_rvalid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  logic          vld_p0;
  logic          vld_p1;
  logic          keep_p1;
  logic [DW-1:0] cpu_rdata_hold;

  // Unregistered select: an async reset clearing sel_hs hands the port back at once.
  assign ram_addr  = sel_hs ? hs_addr  : cpu_addr;
  assign ram_wdata = sel_hs ? hs_wdata : cpu_wdata;
  assign ram_we    = sel_hs ? hs_we    : cpu_we;
  assign cpu_rdata = sel_hs ? cpu_rdata_hold : ram_rdata;

  // p0: address presented to RAM
  assign vld_p0  = sel_hs & rd_en & ~hs_we;
  // p1: RAM data on ram_rdata; dropped if the grant is being released
  assign keep_p1 = vld_p1 & sel_hs & rd_en;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      hs_rvalid <= 1'b0;
      hs_rdata  <= '0;
    end else begin
      vld_p1    <= vld_p0;
      hs_rvalid <= keep_p1;
      if (keep_p1) hs_rdata <= ram_rdata;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!sel_hs) cpu_rdata_hold <= ram_rdata;
  end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Lends the game core work-RAM port to the hiscore engine once the CPU is paused and settled.
// Build option HS_ARB_VBLANK_EN: adds a vblank input; the grant is only given during vertical blank.
module hiscore_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  hiscore_ram_arbiter_if.slave hs,
  output logic                 pause_req,
  input  logic                 cpu_paused,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  input  logic                 cpu_we,
  output logic [DW-1:0]        cpu_rdata,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_wdata,
  output logic                 ram_we,
`ifdef HS_ARB_VBLANK_EN
  input  logic                 vblank,
`endif
  input  logic [DW-1:0]        ram_rdata
);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  hs_arb_state_t    state;
  logic [TO_W-1:0]  to_cnt;
  logic [SET_W-1:0] set_cnt;
  logic             sel_hs;
  logic             timeout_q;
  logic             settle_gate;

`ifdef HS_ARB_VBLANK_EN
  assign settle_gate = vblank;
`else
  assign settle_gate = 1'b1;
`endif

  assign hs.hs_grant   = sel_hs;
  assign hs.hs_timeout = timeout_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pause_req <= 1'b0;
      sel_hs    <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt    <= '0;
      set_cnt   <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs.hs_req) begin
            state     <= S_PAUSE_WAIT;
            pause_req <= 1'b1;
            to_cnt    <= '0;
          end
        end
        S_PAUSE_WAIT: begin
          if (!hs.hs_req) begin
            state     <= S_IDLE;
            pause_req <= 1'b0;
          end else if (cpu_paused) begin
            state   <= S_SETTLE;
            to_cnt  <= '0;
            set_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state     <= S_BLOCKED;
            pause_req <= 1'b0;
            timeout_q <= 1'b1;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (!hs.hs_req || !cpu_paused) begin
            state     <= S_IDLE;
            pause_req <= 1'b0;
          end else if (set_cnt == SET_LAST) begin
            // Count done; hold here until the swap window opens.
            if (settle_gate) begin
              state  <= S_GRANT;
              sel_hs <= 1'b1;
            end
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        S_GRANT: begin
          // A late cpu_paused drop is the pause block's problem; keep the grant.
          if (!hs.hs_req) begin
            state     <= S_IDLE;
            pause_req <= 1'b0;
            sel_hs    <= 1'b0;
          end
        end
        S_BLOCKED: begin
          if (!hs.hs_req) state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          pause_req <= 1'b0;
          sel_hs    <= 1'b0;
        end
      endcase
    end
  end

  hs_arb_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .sel_hs    (sel_hs),
    .rd_en     (hs.hs_req),
    .hs_addr   (hs.hs_addr),
    .hs_wdata  (hs.hs_wdata),
    .hs_we     (hs.hs_we),
    .hs_rdata  (hs.hs_rdata),
    .hs_rvalid (hs.hs_rvalid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: directed scenarios, a per-cycle reference model and a RAM model.
module tb_hiscore_ram_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;

  logic          clk_sys = 1'b0;
  logic          rst_n   = 1'b0;
  logic          pause_req;
  logic          cpu_paused;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata = '0;
`ifdef HS_ARB_VBLANK_EN
  logic          vblank = 1'b1;
`endif

  always #5 clk_sys = ~clk_sys;

  hiscore_ram_arbiter_if #(.AW(AW), .DW(DW)) hs ();

  hiscore_ram_arbiter #(
    .AW(AW), .DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .hs         (hs),
    .pause_req  (pause_req),
    .cpu_paused (cpu_paused),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
`ifdef HS_ARB_VBLANK_EN
    .vblank     (vblank),
`endif
    .ram_rdata  (ram_rdata)
  );

  // RAM model: synchronous read, 1-cycle latency; unwritten cells hold a fixed pattern.
  bit [7:0] mem [65536];
  bit       wr  [65536];

  function automatic logic [7:0] pre_val(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_peek(input logic [15:0] a);
    return wr[a] ? mem[a] : pre_val(a);
  endfunction

  always @(posedge clk_sys) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr[ram_addr]  <= 1'b1;
    end
    ram_rdata <= ram_peek(ram_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for pause ack, 2 settling, 3 granted, 4 blocked.
  typedef struct {
    int        due;
    logic [7:0] data;
  } rd_t;

  rd_t        rq[$];
  int         m_phase  = 0;
  int         m_wait   = 0;
  int         m_settle = 0;
  int         cyc      = 0;
  logic       m_pause  = 1'b0;
  logic       m_grant  = 1'b0;
  logic       m_to     = 1'b0;
  logic       m_hold_ok = 1'b0;
  logic [7:0] m_rdata  = '0;
  logic [7:0] m_hold   = '0;
  logic       vb_ok;

`ifdef HS_ARB_VBLANK_EN
  assign vb_ok = vblank;
`else
  assign vb_ok = 1'b1;
`endif

  initial forever begin
    @(posedge clk_sys or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_wait = 0; m_settle = 0;
      m_pause = 1'b0; m_grant = 1'b0; m_to = 1'b0;
      m_rdata = '0; m_hold_ok = 1'b0;
      rq.delete();
    end else begin
      if (!m_grant) begin
        m_hold    = ram_rdata;
        m_hold_ok = 1'b1;
      end
      m_to = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        m_rdata = rq[0].data;
        rq.delete(0);
      end
      case (m_phase)
        0: if (hs.hs_req) begin m_phase = 1; m_pause = 1'b1; m_wait = 0; end
        1: begin
          if (!hs.hs_req) begin m_phase = 0; m_pause = 1'b0; end
          else if (cpu_paused) begin m_phase = 2; m_settle = 0; end
          else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin m_phase = 4; m_pause = 1'b0; m_to = 1'b1; end
          end
        end
        2: begin
          if (!hs.hs_req || !cpu_paused) begin m_phase = 0; m_pause = 1'b0; end
          else begin
            if (m_settle < SETTLE) m_settle++;
            if (m_settle >= SETTLE && vb_ok) begin m_phase = 3; m_grant = 1'b1; end
          end
        end
        3: begin
          if (!hs.hs_req) begin
            m_phase = 0; m_pause = 1'b0; m_grant = 1'b0;
            rq.delete();
          end else if (!hs.hs_we) begin
            rq.push_back('{cyc + 2, ram_peek(hs.hs_addr)});
          end
        end
        4: if (!hs.hs_req) m_phase = 0;
        default: m_phase = 0;
      endcase
      cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  logic       e_rv;
  logic [7:0] e_rd;
  initial forever begin
    @(negedge clk_sys);
    e_rv = (rq.size() > 0) && (rq[0].due == cyc);
    e_rd = e_rv ? rq[0].data : m_rdata;
    chk("m_pause_req", pause_req,      m_pause);
    chk("m_hs_grant",  hs.hs_grant,    m_grant);
    chk("m_hs_timeout", hs.hs_timeout, m_to);
    chk("m_hs_rvalid", hs.hs_rvalid,   e_rv);
    chk("m_hs_rdata",  hs.hs_rdata,    e_rd);
    chk("m_ram_addr",  ram_addr,  m_grant ? hs.hs_addr  : cpu_addr);
    chk("m_ram_wdata", ram_wdata, m_grant ? hs.hs_wdata : cpu_wdata);
    chk("m_ram_we",    ram_we,    m_grant ? hs.hs_we    : cpu_we);
    if (!m_grant) chk("m_cpu_rdata", cpu_rdata, ram_rdata);
    else if (m_hold_ok) chk("m_cpu_rdata_hold", cpu_rdata, m_hold);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    hs.hs_req = 1'b0; hs.hs_addr = '0; hs.hs_wdata = '0; hs.hs_we = 1'b0;
    cpu_paused = 1'b0; cpu_addr = 16'h0100; cpu_wdata = '0; cpu_we = 1'b0;
    rst_n = 1'b0;
    step(3);
    chk("rst_grant",   hs.hs_grant,   0);
    chk("rst_pause",   pause_req,     0);
    chk("rst_rvalid",  hs.hs_rvalid,  0);
    chk("rst_rdata",   hs.hs_rdata,   0);
    chk("rst_timeout", hs.hs_timeout, 0);
    rst_n = 1'b1;
    step(2);

    // CPU owns the port while idle
    cpu_addr = 16'h0200; cpu_wdata = 8'h77; cpu_we = 1'b1; #1;
    chk("cpu_wr_we", ram_we, 1);
    chk("cpu_wr_addr", ram_addr, 16'h0200);
    step(1); cpu_we = 1'b0;
    step(1);
    chk("cpu_rd_back", cpu_rdata, 8'h77);

    // Request, pause ack 10 cycles later, grant 5 cycles after the ack
    hs.hs_req = 1'b1;
    step(1);
    chk("req_pause", pause_req, 1);
    step(9); cpu_paused = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("settle_nogrant", hs.hs_grant, 0);
      chk("settle_pause", pause_req, 1);
    end
    step(1);
    chk("grant_at_5", hs.hs_grant, 1);

    // Reads under grant; CPU write must not reach RAM
    cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'hEE;
    hs.hs_addr = 16'h1234; hs.hs_we = 1'b0; #1;
    chk("grant_cpu_we_gated", ram_we, 0);
    chk("grant_addr", ram_addr, 16'h1234);
    step(1); hs.hs_addr = 16'h1235; cpu_paused = 1'b0;
    step(1);
    chk("rd_rvalid", hs.hs_rvalid, 1);
    chk("rd_data", hs.hs_rdata, 8'hA5);
    hs.hs_addr = 16'h0010; hs.hs_wdata = 8'h3C; hs.hs_we = 1'b1; #1;
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 16'h0010);
    chk("wr_data", ram_wdata, 8'h3C);
    step(1);
    chk("rd2_rvalid", hs.hs_rvalid, 1);
    chk("rd2_data", hs.hs_rdata, 8'h6F);
    chk("grant_kept_ack_drop", hs.hs_grant, 1);
    chk("cpu_rdata_held", cpu_rdata, 8'h77);
    hs.hs_we = 1'b0;
    step(1);
    chk("wr_no_rvalid", hs.hs_rvalid, 0);
    step(1);
    chk("rd3_rvalid", hs.hs_rvalid, 1);
    chk("rd3_data", hs.hs_rdata, 8'h3C);

    // Release with a read in flight
    hs.hs_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0300;
    step(1);
    chk("drop_grant", hs.hs_grant, 0);
    chk("drop_pause", pause_req, 0);
    chk("drop_rvalid_suppressed", hs.hs_rvalid, 0);
    step(1);
    chk("cpu_write_gated", cpu_rdata, 8'h5A);

    // Pause ack never arrives
    hs.hs_req = 1'b1;
    step(1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      chk("to_wait_pause", pause_req, 1);
      chk("to_wait_nopulse", hs.hs_timeout, 0);
      step(1);
    end
    chk("to_pulse", hs.hs_timeout, 1);
    chk("to_pause_low", pause_req, 0);
    cpu_paused = 1'b1;
    step(1);
    chk("to_pulse_once", hs.hs_timeout, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("blocked_pause", pause_req, 0);
      chk("blocked_grant", hs.hs_grant, 0);
    end
    hs.hs_req = 1'b0; cpu_paused = 1'b0;
    step(2);
    hs.hs_req = 1'b1; cpu_paused = 1'b1;
    step(1);
    chk("retry_pause", pause_req, 1);
    step(5);
    chk("retry_grant", hs.hs_grant, 1);
    hs.hs_req = 1'b0;
    step(2);

    // Request dropped during SETTLE; hs_we while ungranted
    hs.hs_addr = 16'h0400; hs.hs_wdata = 8'h99; hs.hs_we = 1'b1;
    hs.hs_req = 1'b1; cpu_paused = 1'b1; #1;
    chk("ungranted_we_idle", ram_we, 0);
    step(1);
    chk("ungranted_we_wait", ram_we, 0);
    step(1);
    hs.hs_req = 1'b0;
    step(1);
    chk("settle_drop_pause", pause_req, 0);
    for (int i = 0; i < 4; i++) begin
      chk("settle_drop_nogrant", hs.hs_grant, 0);
      step(1);
    end
    hs.hs_we = 1'b0; cpu_paused = 1'b0; cpu_addr = 16'h0400;
    step(1);
    chk("ungranted_we_lost", cpu_rdata, 8'h5A);

    // Asynchronous reset in the middle of a granted write
    hs.hs_req = 1'b1; cpu_paused = 1'b1;
    step(6);
    chk("pre_rst_grant", hs.hs_grant, 1);
    cpu_addr = 16'h0555; hs.hs_addr = 16'h0010; hs.hs_wdata = 8'h11; hs.hs_we = 1'b1; #1;
    chk("pre_rst_we", ram_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_grant", hs.hs_grant, 0);
    chk("arst_pause", pause_req, 0);
    chk("arst_ram_we", ram_we, 0);
    chk("arst_ram_addr", ram_addr, 16'h0555);
    hs.hs_req = 1'b0; hs.hs_we = 1'b0; cpu_paused = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
